// File: rtl/const_materializer_if.sv
// rtl/const_materializer_if.sv - request/instruction handshake bundle for const_materializer
interface const_materializer_if #(
    parameter int CNT_W = 16
) ();
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      value_i;
    logic [4:0]       rd_i;
    logic             instr_valid_o;
    logic             instr_ready_i;
    logic [31:0]      instr_o;
    logic             last_o;
    logic [CNT_W-1:0] cnt_o;

    // Materializer side: consumes requests, produces instructions.
    modport slave (
        input  req_valid_i,
        output req_ready_o,
        input  value_i,
        input  rd_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output last_o,
        output cnt_o
    );

    // Requester / instruction consumer side.
    modport master (
        output req_valid_i,
        input  req_ready_o,
        output value_i,
        output rd_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  last_o,
        input  cnt_o
    );
endinterface

// File: rtl/const_materializer.sv
// rtl/const_materializer.sv - expands a 32-bit constant into a minimal RV32I ADDI / LUI+ADDI sequence
module const_materializer #(
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    const_materializer_if.slave  bus
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT1,
        ST_EMIT2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      addi_q, addi_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      first_instr;
    logic [31:0]      second_instr;
    logic             single;
    logic             fits12;
    logic [19:0]      hi;
    logic [11:0]      lo;

    // Classify the incoming constant and build both candidate instructions.
    // hi is rounded up when lo is negative so that LUI+ADDI sums back to value;
    // the 20-bit add wraps on purpose (0x7FFFF800 -> LUI 0x80000, ADDI -2048).
    always_comb begin
        lo           = bus.value_i[11:0];
        hi           = bus.value_i[31:12] + {19'd0, bus.value_i[11]};
        fits12       = (&bus.value_i[31:11]) | ~(|bus.value_i[31:11]);
        first_instr  = NOP_INSTR;
        second_instr = NOP_INSTR;
        single       = 1'b1;
        if (bus.rd_i == 5'd0) begin
            first_instr = NOP_INSTR;
            single      = 1'b1;
        end else if (fits12) begin
            first_instr = {lo, 5'd0, 3'b000, bus.rd_i, OP_IMM};
            single      = 1'b1;
        end else begin
            first_instr  = {hi, bus.rd_i, OP_LUI};
            second_instr = {lo, bus.rd_i, 3'b000, bus.rd_i, OP_IMM};
            single       = (lo == 12'd0);
        end
    end

    // Sequencer next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addi_d  = addi_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        if (valid_q && bus.instr_ready_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    instr_d = first_instr;
                    addi_d  = second_instr;
                    last_d  = single;
                    valid_d = 1'b1;
                    state_d = ST_EMIT1;
                end
            end
            ST_EMIT1: begin
                if (bus.instr_ready_i) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        instr_d = addi_q;
                        last_d  = 1'b1;
                        state_d = ST_EMIT2;
                    end
                end
            end
            ST_EMIT2: begin
                if (bus.instr_ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            instr_q <= 32'd0;
            addi_q  <= 32'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addi_q  <= addi_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready_o   = (state_q == ST_IDLE);
    assign bus.instr_valid_o = valid_q;
    assign bus.instr_o       = instr_q;
    assign bus.last_o        = last_q;
    assign bus.cnt_o         = cnt_q;
endmodule

// File: tb/tb_const_materializer.sv
// tb/tb_const_materializer.sv - randomized scoreboard bench for const_materializer
module tb_const_materializer;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;

    const_materializer_if #(.CNT_W(CNT_W)) bus ();

    const_materializer #(.CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
    } beat_t;

    beat_t            exp_q[$];
    logic [31:0]      lit_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    bit               started = 1'b0;
    int               checks  = 0;
    int               errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_addi(input longint imm, input longint rs1, input longint rd);
        return 32'(imm * 1048576 + rs1 * 32768 + rd * 128 + 19);
    endfunction

    // Reference: what instructions must come out for a given constant.
    function automatic void model(input logic [31:0] v, input logic [4:0] r,
                                  output int n, output logic [31:0] i0, output logic [31:0] i1);
        int     sv;
        longint uv;
        longint hi;
        longint lo;
        sv = $signed(v);
        uv = longint'(v);
        i0 = 32'h13;
        i1 = 32'h13;
        n  = 1;
        if (r == 5'd0) begin
            n = 1;
        end else if (sv >= -2048 && sv <= 2047) begin
            i0 = enc_addi(uv % 4096, 0, longint'(r));
        end else begin
            lo = uv % 4096;
            hi = ((uv + 2048) / 4096) % 1048576;
            i0 = 32'(hi * 4096 + longint'(r) * 128 + 55);
            if (lo != 0) begin
                n  = 2;
                i1 = enc_addi(lo, longint'(r), longint'(r));
            end
        end
    endfunction

    task automatic push_model(input logic [31:0] v, input logic [4:0] r);
        int          n;
        logic [31:0] i0;
        logic [31:0] i1;
        model(v, r, n, i0, i1);
        exp_q.push_back('{instr: i0, last: (n == 1)});
        if (n == 2) exp_q.push_back('{instr: i1, last: 1'b1});
    endtask

    // Compare process: every cycle, check DUT against the scoreboard, then advance it.
    initial begin
        logic [31:0] l;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("instr_valid", {31'd0, bus.instr_valid_o}, {31'd0, exp_q.size() > 0});
                chk("req_ready", {31'd0, bus.req_ready_o}, {31'd0, exp_q.size() == 0});
                chk("cnt", 32'(bus.cnt_o), 32'(exp_cnt));
                if (exp_q.size() > 0 && bus.instr_valid_o) begin
                    chk("instr", bus.instr_o, exp_q[0].instr);
                    chk("last", {31'd0, bus.last_o}, {31'd0, exp_q[0].last});
                end
                if (rst) begin
                    exp_q.delete();
                    lit_q.delete();
                    exp_cnt = '0;
                end else if (exp_q.size() > 0) begin
                    if (bus.instr_ready_i) begin
                        void'(exp_q.pop_front());
                        if (lit_q.size() > 0) begin
                            l = lit_q.pop_front();
                            chk("literal", bus.instr_o, l);
                        end
                        exp_cnt = exp_cnt + 1'b1;
                    end
                end else if (bus.req_valid_i) begin
                    push_model(bus.value_i, bus.rd_i);
                end
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [4:0] r);
        int t;
        t = 0;
        while (!bus.req_ready_o && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: req_ready_o stayed 0 for %0d cycles, required 1", t);
        end
        bus.req_valid_i = 1'b1;
        bus.value_i     = v;
        bus.rd_i        = r;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.value_i     = $urandom;
        bus.rd_i        = 5'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !bus.req_ready_o) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", t);
        end
    endtask

    function automatic logic [31:0] rand_value();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: v = {v[31:12], 12'h000};
            2: v = {v[31:12], 12'h800};
            3: case ($urandom_range(0, 3))
                   0: v = 32'h7FFF_F800;
                   1: v = 32'hFFFF_F7FF;
                   2: v = 32'h0000_0800;
                   default: v = 32'hFFFF_F800;
               endcase
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int          n;
        logic [31:0] i0;
        logic [31:0] i1;

        rst               = 1'b1;
        bus.req_valid_i   = 1'b0;
        bus.value_i       = 32'd0;
        bus.rd_i          = 5'd0;
        bus.instr_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;
        @(negedge clk);
        chk("rst_instr", bus.instr_o, 32'd0);
        chk("rst_last", {31'd0, bus.last_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rst_cnt", 32'(bus.cnt_o), 32'd0);
        @(posedge clk); #1;

        model(32'h7FFF_F800, 5'd1, n, i0, i1);
        chk("model_wrap_n", 32'(n), 32'd2);
        chk("model_wrap_lui", i0, 32'h8000_00B7);
        chk("model_wrap_addi", i1, 32'h8000_8093);
        model(32'hABCD_E000, 5'd7, n, i0, i1);
        chk("model_lui_only", i0, 32'hABCD_E3B7);

        bus.instr_ready_i = 1'b1;
        lit_q.push_back(32'h7FF0_0293);
        send(32'h0000_07FF, 5'd5);
        lit_q.push_back(32'h8000_0093);
        send(32'hFFFF_F800, 5'd1);
        lit_q.push_back(32'h1234_5537);
        lit_q.push_back(32'h6785_0513);
        send(32'h1234_5678, 5'd10);
        lit_q.push_back(32'h0000_11B7);
        lit_q.push_back(32'h8001_8193);
        send(32'h0000_0800, 5'd3);
        lit_q.push_back(32'hABCD_E3B7);
        send(32'hABCD_E000, 5'd7);
        lit_q.push_back(32'h0000_0013);
        send(32'h1234_5678, 5'd0);
        wait_idle();

        bus.instr_ready_i = 1'b0;
        lit_q.push_back(32'h1234_5537);
        lit_q.push_back(32'h6785_0513);
        send(32'h1234_5678, 5'd10);
        for (int i = 0; i < 3; i++) begin
            bus.req_valid_i = (i == 1);
            bus.value_i     = 32'h0000_07FF;
            bus.rd_i        = 5'd5;
            @(posedge clk); #1;
        end
        bus.req_valid_i   = 1'b0;
        bus.instr_ready_i = 1'b1;
        wait_idle();

        lit_q.push_back(32'h1234_5537);
        send(32'h1234_5678, 5'd10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lit_q.push_back(32'h7FF0_0293);
        send(32'h0000_07FF, 5'd5);
        wait_idle();

        for (int c = 0; c < 4000; c++) begin
            bus.req_valid_i   = ($urandom_range(0, 2) != 0);
            bus.value_i       = rand_value();
            bus.rd_i          = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            bus.instr_ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        bus.req_valid_i   = 1'b0;
        bus.instr_ready_i = 1'b1;
        wait_idle();
        chk("literals_consumed", 32'(lit_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/const_materializer.md
Name: const_materializer

Overview:
- Inverse of the decode-side immediate sign extender: takes a 32-bit constant and a destination register, and emits the minimal RV32I instruction sequence that loads the constant into that register.
- Sequence is either ADDI alone, or LUI followed by ADDI, with LUI+ADDI rounding correction.
- Sits ahead of the instruction fetch/issue path as a micro-sequencer (boot ROM patching, test stimulus, pseudo-instruction "li" expansion).
- Uses a valid/ready handshake on both input and output sides.

Parameters:
- CNT_W, 16, width of the emitted-instruction counter cnt_o; wraps modulo 2^CNT_W.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- value_i  in  32  constant to materialize
- rd_i  in  5  destination register index
- instr_valid_o  out  1  instr_o holds a valid instruction
- instr_ready_i  in  1  downstream accepts instr_o
- instr_o  out  32  encoded RV32I instruction
- last_o  out  1  instr_o is the final instruction of the current sequence
- cnt_o  out  CNT_W  count of instructions handed off (instr_valid_o & instr_ready_i)

Behaviour:
- Reset (synchronous, rst_i=1 at edge):
  - state=IDLE; req_ready_o=1; instr_valid_o=0; instr_o=0; last_o=0; cnt_o=0.
  - Reset mid-sequence abandons the sequence with no further output.
- States and transitions:
  - IDLE: req_ready_o=1. On req_valid_i&req_ready_o, latch value_i and rd_i, classify, load the first instruction into instr_o, set instr_valid_o=1, go to EMIT1. First instruction appears the cycle after acceptance (latency 1).
  - EMIT1: req_ready_o=0. On instr_ready_i:
    - if last_o=1, drop instr_valid_o and go to IDLE;
    - else load the ADDI into instr_o, keep instr_valid_o=1, set last_o=1, go to EMIT2.
  - EMIT2: req_ready_o=0. On instr_ready_i, drop instr_valid_o and go to IDLE.
- Request acceptance: requests are accepted only in IDLE. Throughput is one request per (instructions+1) cycles at best.
- Output stability: while instr_valid_o=1 and instr_ready_i=0, instr_o and last_o are held stable.
- Classification (v=value, r=rd):
  - r==0: emit single NOP 0x00000013, last_o=1.
  - v[31:11] all equal (fits signed 12-bit): single ADDI r,x0,v[11:0], last_o=1.
  - Otherwise: lo=v[11:0], hi=(v[31:12]+v[11]) mod 2^20.
    - Emit LUI r,hi.
    - If lo!=0, follow with ADDI r,r,lo (last_o=1 on the ADDI only).
    - If lo==0, emit LUI only, last_o=1.
- Wrap rule: the hi addition wraps silently. Example: v=0x7FFFF800 gives hi=0x80000, lo=0x800; LUI 0x80000 then ADDI -2048 yields 0x7FFFF800.
- Encodings:
  - ADDI = {imm[11:0], rs1, 3'b000, rd, 7'b0010011}
  - LUI = {imm[19:0], rd, 7'b0110111}
- Counter: cnt_o increments by 1 on each cycle with instr_valid_o&instr_ready_i; wraps at 2^CNT_W-1 to 0.
- Input handling: req_valid_i while not ready is ignored (not queued). value_i and rd_i are sampled only at acceptance.
- Invariants: outputs are registered (no combinational path from instr_ready_i to instr_o). instr_ready_i with instr_valid_o=0 has no effect.

Test Plan:
- Reset, then value=0x000007FF, rd=5, instr_ready_i=1 -> one cycle after acceptance, instr_o=0x7FF00293, last_o=1; IDLE next cycle; cnt_o=1.
- value=0xFFFFF800, rd=1 -> single instr_o=0x80000093 (ADDI x1,x0,-2048), last_o=1.
- value=0x12345678, rd=10 -> instr_o=0x12345537 (last_o=0), then 0x67850513 (last_o=1); cnt_o increments by 2. Repeat with value=0x00000800, rd=3 -> 0x000011B7 then 0x80018193 (rounding correction).
- value=0xABCDE000, rd=7 -> single LUI 0xABCDE3B7 with last_o=1. value=0x12345678, rd=0 -> single 0x00000013.
- Backpressure: case 0x12345678/rd=10 with instr_ready_i=0 for 3 cycles on the first beat -> instr_o=0x12345537 held stable, req_ready_o=0, a req_valid_i pulse is ignored; cnt_o unchanged until the handshake.
- rst_i asserted in EMIT2 of a two-instruction sequence -> next cycle instr_valid_o=0, cnt_o=0, req_ready_o=1; a new request of 0x000007FF, rd=5 completes normally.
